// File: rtl/return_addr_stack_if.sv
// Command/response bundle between the control FSM and the return-address stack.
// The master drives commands; the slave (the stack) returns status and popped addresses.
interface return_addr_stack_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 3
);
    logic             en;
    logic [1:0]       sr;
    logic [WIDTH-1:0] address;
    logic [WIDTH-1:0] raout;
    logic             ra_valid;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output en, sr, address,
        input  raout, ra_valid, count, empty, full, overflow, underflow
    );

    modport slave (
        input  en, sr, address,
        output raout, ra_valid, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/return_addr_stack.sv
// Circular LIFO of return addresses: store pushes address+4, restore pops into raout.
// Overflow overwrites the oldest entry; overflow/underflow flags are sticky until rst or flush.
module return_addr_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input logic                clk,
    input logic                rst,
    return_addr_stack_if.slave bus
);
    typedef enum logic [1:0] {
        CMD_HOLD    = 2'd0,
        CMD_STORE   = 2'd1,
        CMD_FLUSH   = 2'd2,
        CMD_RESTORE = 2'd3
    } cmd_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    sp;
    logic [AW-1:0]    sp_m1;
    logic [AW:0]      cnt;
    logic [WIDTH-1:0] raout_q;
    logic             ra_valid_q;
    logic             ovf_q;
    logic             unf_q;
    cmd_t             cmd;
    logic             is_empty;
    logic             is_full;

    // A disabled port behaves exactly like an explicit hold command.
    always_comb begin
        cmd = CMD_HOLD;
        if (bus.en) begin
            cmd = cmd_t'(bus.sr);
        end
    end

    always_comb begin
        sp_m1    = sp - 1'b1;
        is_empty = (cnt == '0);
        is_full  = (cnt == FULL_CNT);
    end

    // Storage carries no reset; only count decides which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && cmd == CMD_STORE) begin
            mem[sp] <= bus.address + WIDTH'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp         <= '0;
            cnt        <= '0;
            raout_q    <= '0;
            ra_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            ra_valid_q <= 1'b0;
            unique case (cmd)
                CMD_STORE: begin
                    sp <= sp + 1'b1;
                    if (is_full) begin
                        ovf_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CMD_FLUSH: begin
                    sp    <= '0;
                    cnt   <= '0;
                    ovf_q <= 1'b0;
                    unf_q <= 1'b0;
                end
                CMD_RESTORE: begin
                    if (!is_empty) begin
                        raout_q    <= mem[sp_m1];
                        sp         <= sp_m1;
                        cnt        <= cnt - 1'b1;
                        ra_valid_q <= 1'b1;
                    end else begin
                        unf_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.raout     = raout_q;
    assign bus.ra_valid  = ra_valid_q;
    assign bus.count     = cnt;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack with a queue-based reference stack and
// a scoreboard of expected popped addresses.
module tb_return_addr_stack;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] m_stack[$];
    logic [31:0] exp_q[$];
    logic [31:0] m_raout = '0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic        exp_v = 1'b0;

    return_addr_stack_if #(.WIDTH(32), .AW(3)) bus ();

    return_addr_stack #(.WIDTH(32), .DEPTH(8), .AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_status(input string tag);
        logic [31:0] cnt;
        cnt = 32'(m_stack.size());
        chk({tag, ".ra_valid"}, 32'(bus.ra_valid), 32'(exp_v));
        if (exp_v) begin
            if (exp_q.size() == 0) begin
                chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
            end else begin
                chk({tag, ".raout"}, bus.raout, exp_q.pop_front());
            end
        end else begin
            chk({tag, ".raout_held"}, bus.raout, m_raout);
        end
        chk({tag, ".count"}, 32'(bus.count), cnt);
        chk({tag, ".empty"}, 32'(bus.empty), 32'(cnt == 0));
        chk({tag, ".full"}, 32'(bus.full), 32'(cnt == 8));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
    endtask

    task automatic cmd(input string tag, input logic e, input logic [1:0] s, input logic [31:0] a);
        logic [31:0] v;
        @(negedge clk);
        bus.en = e; bus.sr = s; bus.address = a;
        exp_v = 1'b0;
        if (e) begin
            case (s)
                2'd1: begin
                    v = a + 32'd4;
                    if (m_stack.size() == 8) begin
                        void'(m_stack.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_stack.push_back(v);
                end
                2'd2: begin
                    m_stack.delete();
                    m_ovf = 1'b0;
                    m_unf = 1'b0;
                end
                2'd3: begin
                    if (m_stack.size() > 0) begin
                        v = m_stack.pop_back();
                        exp_q.push_back(v);
                        m_raout = v;
                        exp_v = 1'b1;
                    end else begin
                        m_unf = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        chk_status(tag);
    endtask

    task automatic do_reset(input int cycles, input logic [1:0] s);
        @(negedge clk);
        rst = 1'b1; bus.en = 1'b1; bus.sr = s; bus.address = 32'h40;
        repeat (cycles) @(posedge clk);
        #1;
        m_stack.delete();
        m_raout = '0; m_ovf = 1'b0; m_unf = 1'b0; exp_v = 1'b0;
        chk_status("reset");
        @(negedge clk);
        rst = 1'b0; bus.en = 1'b0; bus.sr = 2'd0;
    endtask

    initial begin
        bus.en = 1'b0; bus.sr = 2'd0; bus.address = '0;

        // 1: reset state
        do_reset(2, 2'd0);

        // 2: store then restore, pulse lasts one cycle
        cmd("t2_store", 1'b1, 2'd1, 32'd244);
        cmd("t2_restore", 1'b1, 2'd3, 32'd0);
        chk("t2_raout_lit", bus.raout, 32'd248);
        cmd("t2_idle", 1'b1, 2'd0, 32'd0);

        // 3: three stores, three back-to-back restores
        cmd("t3_s100", 1'b1, 2'd1, 32'd100);
        cmd("t3_s200", 1'b1, 2'd1, 32'd200);
        cmd("t3_s300", 1'b1, 2'd1, 32'd300);
        cmd("t3_r0", 1'b1, 2'd3, 32'd0);
        cmd("t3_r1", 1'b1, 2'd3, 32'd0);
        cmd("t3_r2", 1'b1, 2'd3, 32'd0);
        chk("t3_last_lit", bus.raout, 32'd104);
        cmd("t3_idle", 1'b0, 2'd3, 32'd0);

        // 4: overflow by one, oldest entry lost
        for (int i = 0; i < 9; i++) cmd("t4_store", 1'b1, 2'd1, 32'(i * 4));
        chk("t4_full_lit", 32'(bus.full), 32'd1);
        for (int i = 0; i < 8; i++) cmd("t4_restore", 1'b1, 2'd3, 32'd0);
        chk("t4_last_lit", bus.raout, 32'd8);

        // 5: underflow then flush; overflow from step 4 is still sticky here
        cmd("t5_underflow", 1'b1, 2'd3, 32'd0);
        cmd("t5_flush", 1'b1, 2'd2, 32'd0);

        // 6: disabled store, wrap of address+4, reset mid-sequence
        cmd("t6_en0", 1'b0, 2'd1, 32'd500);
        cmd("t6_wrap_store", 1'b1, 2'd1, 32'hFFFF_FFFC);
        cmd("t6_wrap_restore", 1'b1, 2'd3, 32'd0);
        chk("t6_wrap_lit", bus.raout, 32'h0000_0000);
        cmd("t6_store_a", 1'b1, 2'd1, 32'h1000);
        cmd("t6_store_b", 1'b1, 2'd1, 32'h2000);
        do_reset(1, 2'd1);
        cmd("t6_post_rst_restore", 1'b1, 2'd3, 32'd0);
        cmd("t6_store_c", 1'b1, 2'd1, 32'h3000);
        cmd("t6_restore_c", 1'b1, 2'd3, 32'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
